// File: rtl/eth_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : eth_tx_pkg
// Purpose  : Shared types and helpers for the Ethernet TX arbiter.
//            Holds the arbiter state encoding, the default timing/length
//            limits and a one-hot to index conversion.
// Contents : state_t             one-hot 4-bit arbiter state
//            DEF_START_TIMEOUT   default cycles allowed before the first byte
//            DEF_MAX_BYTES       default maximum bytes per burst (incl. CRC)
//            IDX_W               width of a requester index
//            onehot_to_index()   one-hot (up to 8 bits) to binary index
// Revision : 1.0 - initial release
// ============================================================================
package eth_tx_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_GRANT = 4'b0010,
    ST_SEND  = 4'b0100,
    ST_DRAIN = 4'b1000
  } state_t;

  localparam int DEF_START_TIMEOUT = 16;
  localparam int DEF_MAX_BYTES     = 1522;
  localparam int IDX_W             = 3;

  // OR-ing the indices of the set bits is exact for a one-hot input and
  // yields 0 for an all-zero input.
  function automatic logic [IDX_W-1:0] onehot_to_index(input logic [7:0] onehot);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (onehot[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/eth_tx_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : rr_picker
// Purpose  : Combinational round-robin search. Returns the first requester
//            with req set, searching upward from ptr+1 with wrap-around.
// Ports    : req     in  NUM_REQ  request vector
//            ptr     in  3        index of the most recent winner
//            winner  out 3        index of the selected requester
//            found   out 1        at least one request is set
// Revision : 1.0 - initial release
// ============================================================================
module rr_picker
  import eth_tx_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               found
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [2*NUM_REQ-1:0] shifted;
  logic [NUM_REQ-1:0]   rot;
  logic [3:0]           sum;

  always_comb begin
    // Rotate so that bit 0 of rot corresponds to requester ptr+1. With
    // NUM_REQ=8 and ptr=7 the 3-bit add wraps to 0, which is exactly ptr+1.
    dbl     = {req, req};
    shifted = dbl >> (ptr + 3'd1);
    rot     = shifted[NUM_REQ-1:0];
    winner  = '0;
    found   = 1'b0;
    sum     = '0;
    // Descending scan: the lowest rotated offset is written last and wins.
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (rot[j]) begin
        sum = {1'b0, ptr} + 4'd1 + 4'(j);
        if (sum >= 4'(NUM_REQ)) sum = sum - 4'(NUM_REQ);
        winner = sum[IDX_W-1:0];
        found  = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/eth_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : eth_tx_arbiter
// Purpose  : Shares one RGMII byte-stream transmitter among NUM_REQ frame
//            sources using round-robin grants. Forwards the granted source's
//            bytes with one cycle of latency, enforces a start timeout and a
//            maximum burst length, and waits for the transmitter to finish
//            purge and inter-frame gap before the next grant.
// Ports    : clock       in   1          system clock (shared with the PHY)
//            reset_n     in   1          asynchronous active-low reset
//            req         in   NUM_REQ    per-source request
//            req_valid   in   NUM_REQ    per-source byte strobe
//            req_data    in   8*NUM_REQ  per-source byte, source i at [8i+7:8i]
//            grant       out  NUM_REQ    one-hot grant or zero
//            phy_active  in   1          transmitter busy (send/purge/gap)
//            tx_data     out  8          byte to transmitter
//            tx_enable   out  1          byte strobe to transmitter
//            abort       out  1          one-cycle forced-termination pulse
//            abort_id    out  3          index of the aborted requester
// Revision : 1.0 - initial release
// ============================================================================
module eth_tx_arbiter
  import eth_tx_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = DEF_START_TIMEOUT,
  parameter int MAX_BYTES     = DEF_MAX_BYTES,
  parameter int CW            = 11
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   grant,
  input  logic                 phy_active,
  output logic [7:0]           tx_data,
  output logic                 tx_enable,
  output logic                 abort,
  output logic [IDX_W-1:0]     abort_id
);

  localparam int TW = $clog2(START_TIMEOUT + 1);

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [TW-1:0]      tcnt;
  logic [CW-1:0]      bcnt;
  logic               drain_first;

  logic [IDX_W-1:0]   winner;
  logic               found;
  logic [NUM_REQ-1:0] win_onehot;
  logic [IDX_W-1:0]   g_idx;
  logic               cur_valid;
  logic               cur_req;
  logic [7:0]         cur_data;

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req    (req),
    .ptr    (ptr),
    .winner (winner),
    .found  (found)
  );

  assign win_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
  assign g_idx      = onehot_to_index(8'(grant));

  // grant is one-hot, so masking selects the granted source's signals and
  // everything from non-granted sources is ignored.
  assign cur_valid = |(req_valid & grant);
  assign cur_req   = |(req & grant);

  always_comb begin
    cur_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) cur_data = cur_data | req_data[8*i +: 8];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      grant       <= '0;
      ptr         <= IDX_W'(NUM_REQ - 1);
      tcnt        <= '0;
      bcnt        <= '0;
      drain_first <= 1'b0;
      tx_data     <= '0;
      tx_enable   <= 1'b0;
      abort       <= 1'b0;
      abort_id    <= '0;
    end else begin
      abort <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (found && !phy_active) begin
            grant <= win_onehot;
            ptr   <= winner;
            tcnt  <= '0;
            bcnt  <= '0;
            state <= ST_GRANT;
          end
        end

        ST_GRANT: begin
          if (cur_valid) begin
            // The first byte is forwarded here so every byte sees the same
            // single-cycle latency.
            tx_enable <= 1'b1;
            tx_data   <= cur_data;
            bcnt      <= CW'(1);
            state     <= ST_SEND;
          end else if (!cur_req) begin
            grant <= '0;
            state <= ST_IDLE;
          end else if (tcnt == TW'(START_TIMEOUT - 1)) begin
            grant    <= '0;
            abort    <= 1'b1;
            abort_id <= g_idx;
            state    <= ST_IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        ST_SEND: begin
          if (!cur_valid) begin
            tx_enable   <= 1'b0;
            grant       <= '0;
            drain_first <= 1'b1;
            state       <= ST_DRAIN;
          end else if (bcnt == CW'(MAX_BYTES)) begin
            // Oversize frame: drop this byte and everything after it; the
            // receiver discards the truncated frame on CRC.
            tx_enable   <= 1'b0;
            grant       <= '0;
            abort       <= 1'b1;
            abort_id    <= g_idx;
            drain_first <= 1'b1;
            state       <= ST_DRAIN;
          end else begin
            tx_data <= cur_data;
            bcnt    <= bcnt + 1'b1;
          end
        end

        ST_DRAIN: begin
          // phy_active may not yet reflect the last byte on the first cycle.
          if (drain_first) begin
            drain_first <= 1'b0;
          end else if (!phy_active) begin
            state <= ST_IDLE;
          end
        end

        default: begin
          state     <= ST_IDLE;
          grant     <= '0;
          tx_enable <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_eth_tx_arbiter
// Purpose  : Scoreboard bench for eth_tx_arbiter. Source drivers push the
//            bytes, bursts and aborts the rules call for; a monitor pops and
//            compares whenever the arbiter presents output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eth_tx_arbiter;

  localparam int N    = 4;
  localparam int TO   = 16;
  localparam int MAXB = 1522;

  localparam int S_IDLE = 0;
  localparam int S_REQ  = 1;
  localparam int S_SEND = 2;

  logic           clock = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   grant;
  logic           phy_active;
  logic [7:0]     tx_data;
  logic           tx_enable;
  logic           abort;
  logic [2:0]     abort_id;

  eth_tx_arbiter #(
    .NUM_REQ       (N),
    .START_TIMEOUT (TO),
    .MAX_BYTES     (MAXB),
    .CW            (11)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req        (req),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .grant      (grant),
    .phy_active (phy_active),
    .tx_data    (tx_data),
    .tx_enable  (tx_enable),
    .abort      (abort),
    .abort_id   (abort_id)
  );

  always #5 clock = ~clock;

  typedef struct {int src; int len; int delay; int gap_at; bit noshow;} plan_t;
  typedef struct {int id; int len; int start;} frame_t;

  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;

  plan_t      pend[$];
  logic [7:0] byte_q[$];
  frame_t     frame_q[$];
  int         abort_q[$];
  int         gseq[$];

  int         st[N];
  int         kk[N];
  int         gcnt[N];
  int         dly[N];
  int         explen[N];
  plan_t      cur[N];
  int         start_pct = 100;
  int         phy_gap   = 0;
  bit         do_reset  = 1'b0;

  int         last_win = N - 1;
  bit         in_b     = 1'b0;
  bit         have_fr  = 1'b0;
  int         blen     = 0;
  frame_t     fr;
  logic [N-1:0] pg = '0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
    end
  endtask

  // Round-robin rule: first requester after the previous winner, wrapping.
  function automatic int rr_expect(input logic [N-1:0] r, input int from);
    logic [N-1:0] t;
    for (int s = 1; s <= N; s++) begin
      t = r >> ((from + s) % N);
      if (t[0]) return (from + s) % N;
    end
    return -1;
  endfunction

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Transmitter model: busy while sending, then purge + gap of a few cycles.
  task automatic phy_step();
    if (tx_enable) begin
      phy_active = 1'b1;
      phy_gap    = $urandom_range(10, 2);
    end else if (phy_gap > 0) begin
      phy_gap--;
      phy_active = 1'b1;
    end else begin
      phy_active = 1'b0;
    end
  endtask

  task automatic send_cycle(input int i);
    int total;
    int b;
    logic [7:0] d;
    total = cur[i].len + ((cur[i].gap_at > 0) ? 1 : 0);
    if (kk[i] >= total) begin
      req_valid[i] = 1'b0;
      st[i]        = S_IDLE;
    end else if (cur[i].gap_at > 0 && kk[i] == cur[i].gap_at) begin
      req_valid[i] = 1'b0;
      kk[i]++;
    end else begin
      d = 8'($urandom);
      b = (cur[i].gap_at > 0 && kk[i] > cur[i].gap_at) ? kk[i] - 1 : kk[i];
      req_valid[i]       = 1'b1;
      req_data[8*i +: 8] = d;
      if (b < explen[i]) byte_q.push_back(d);
      if (cur[i].gap_at == 0 && b == MAXB) abort_q.push_back(i);
      kk[i]++;
    end
  endtask

  task automatic src_step(input int i);
    case (st[i])
      S_IDLE: begin
        req[i]       = 1'b0;
        req_valid[i] = 1'b0;
        if ($urandom_range(99) < start_pct) begin
          for (int p = 0; p < pend.size(); p++) begin
            if (pend[p].src == i) begin
              cur[i] = pend[p];
              pend.delete(p);
              st[i]   = S_REQ;
              req[i]  = 1'b1;
              gcnt[i] = 0;
              dly[i]  = cur[i].delay;
              break;
            end
          end
        end
      end
      S_REQ: begin
        if (grant[i]) begin
          if (cur[i].noshow) begin
            gcnt[i]++;
            if (gcnt[i] == 1) abort_q.push_back(i);
          end else if (dly[i] > 0) begin
            dly[i]--;
          end else begin
            st[i]  = S_SEND;
            req[i] = 1'b0;
            kk[i]  = 0;
            explen[i] = (cur[i].gap_at > 0) ? cur[i].gap_at
                      : ((cur[i].len > MAXB) ? MAXB : cur[i].len);
            frame_q.push_back('{i, explen[i], cyc + 1});
            send_cycle(i);
          end
        end else if (cur[i].noshow && gcnt[i] > 0) begin
          chk("timeout_grant_cycles", gcnt[i], TO);
          st[i]  = S_IDLE;
          req[i] = 1'b0;
        end
      end
      default: send_cycle(i);
    endcase
  endtask

  // Driver: all DUT inputs change on the falling edge.
  initial begin
    reset_n    = 1'b0;
    req        = '0;
    req_valid  = '0;
    req_data   = '0;
    phy_active = 1'b0;
    for (int i = 0; i < N; i++) st[i] = S_IDLE;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    forever begin
      @(negedge clock);
      if (do_reset) begin
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_tx_enable", int'(tx_enable), 0);
        chk("async_rst_grant", int'(grant), 0);
        byte_q.delete();
        frame_q.delete();
        abort_q.delete();
        for (int i = 0; i < N; i++) begin
          req_valid[i] = 1'b0;
          if (st[i] != S_IDLE) begin
            cur[i]  = '{i, 40, 1, 0, 1'b0};
            st[i]   = S_REQ;
            req[i]  = 1'b1;
            gcnt[i] = 0;
            dly[i]  = 1;
          end
        end
        do_reset = 1'b0;
        repeat (2) begin
          @(negedge clock);
          phy_step();
        end
        reset_n = 1'b1;
        continue;
      end
      phy_step();
      for (int i = 0; i < N; i++) src_step(i);
    end
  end

  // Monitor: samples 1 ns after each rising edge.
  initial forever begin
    int exp_w;
    int obs;
    int ea;
    logic [7:0] eb;
    @(posedge clock);
    #1;
    if (!reset_n) begin
      last_win = N - 1;
      in_b     = 1'b0;
      have_fr  = 1'b0;
      pg       = '0;
      continue;
    end
    if (grant != pg && grant != '0) begin
      chk("grant_onehot", int'($onehot(grant) && pg == '0), 1);
      exp_w = rr_expect(req, last_win);
      chk("grant_order", int'(grant), (exp_w < 0) ? 0 : (1 << exp_w));
      chk("grant_while_phy_idle", int'(phy_active), 0);
      obs = 0;
      for (int j = 0; j < N; j++) if (grant[j]) obs = j;
      gseq.push_back(obs);
      if (exp_w >= 0) last_win = exp_w;
    end
    pg = grant;
    if (tx_enable) begin
      if (!in_b) begin
        in_b = 1'b1;
        blen = 0;
        if (frame_q.size() == 0) begin
          have_fr = 1'b0;
          chk("burst_expected", 0, 1);
        end else begin
          fr      = frame_q.pop_front();
          have_fr = 1'b1;
          chk("tx_latency_cycle", cyc, fr.start);
        end
      end
      if (byte_q.size() == 0) begin
        chk("tx_byte_expected", 0, 1);
      end else begin
        eb = byte_q.pop_front();
        chk("tx_data", int'(tx_data), int'(eb));
      end
      blen++;
    end else if (in_b) begin
      in_b = 1'b0;
      if (have_fr) chk("burst_len", blen, fr.len);
    end
    if (abort) begin
      if (abort_q.size() == 0) begin
        chk("abort_expected", 0, 1);
      end else begin
        ea = abort_q.pop_front();
        chk("abort_id", int'(abort_id), ea);
      end
    end
  end

  task automatic wait_quiet(input string tag, input int budget);
    int n;
    bit busy;
    n    = 0;
    busy = 1'b1;
    while (busy && n < budget) begin
      @(posedge clock);
      #2;
      n++;
      busy = (pend.size() != 0) || (grant != '0) || tx_enable || phy_active;
      for (int i = 0; i < N; i++) if (st[i] != S_IDLE) busy = 1'b1;
    end
    chk(tag, int'(busy), 0);
    repeat (4) @(posedge clock);
  endtask

  initial begin
    int p1_exp[5];
    int n;
    int ln;
    p1_exp = '{0, 1, 2, 3, 0};

    #12;
    chk("reset_grant", int'(grant), 0);
    chk("reset_tx_enable", int'(tx_enable), 0);
    chk("reset_tx_data", int'(tx_data), 0);
    chk("reset_abort", int'(abort), 0);
    chk("reset_abort_id", int'(abort_id), 0);
    repeat (4) @(posedge clock);

    // All four request together, source 0 twice.
    gseq.delete();
    pend.push_back('{0, 64, 0, 0, 1'b0});
    pend.push_back('{0, 64, 0, 0, 1'b0});
    for (int s = 1; s < N; s++) pend.push_back('{s, 64, 0, 0, 1'b0});
    wait_quiet("quiet_rr", 3000);
    chk("rr_grant_count", gseq.size(), 5);
    for (int j = 0; j < 5 && j < gseq.size(); j++) chk("rr_grant_seq", gseq[j], p1_exp[j]);

    // Single 60-byte frame from source 1.
    pend.push_back('{1, 60, 0, 0, 1'b0});
    wait_quiet("quiet_single", 1000);

    // Source 2 never sends; source 3 is pending behind it.
    pend.push_back('{2, 0, 0, 0, 1'b1});
    pend.push_back('{3, 30, 2, 0, 1'b0});
    wait_quiet("quiet_timeout", 1000);

    // Oversize frame.
    pend.push_back('{0, 1600, 0, 0, 1'b0});
    wait_quiet("quiet_oversize", 4000);

    // 10 bytes, one idle cycle, 10 more bytes.
    pend.push_back('{1, 20, 0, 10, 1'b0});
    wait_quiet("quiet_gap", 1000);

    // Randomized traffic.
    start_pct = 30;
    for (int f = 0; f < 40; f++) begin
      ln = $urandom_range(120, 1);
      pend.push_back('{int'($urandom_range(N - 1)), ln, int'($urandom_range(4)),
                       (ln > 1 && $urandom_range(7) == 0) ? int'($urandom_range(ln - 1, 1)) : 0,
                       ($urandom_range(9) == 0)});
    end
    wait_quiet("quiet_random", 40000);

    // Reset mid-burst, request still held afterwards.
    start_pct = 100;
    pend.push_back('{2, 300, 0, 0, 1'b0});
    n = 0;
    while (!tx_enable && n < 200) begin
      @(posedge clock);
      #2;
      n++;
    end
    chk("reset_phase_burst_started", int'(tx_enable), 1);
    repeat (50) @(posedge clock);
    do_reset = 1'b1;
    n = 0;
    while (do_reset && n < 100) begin
      @(posedge clock);
      n++;
    end
    chk("reset_phase_handled", int'(do_reset), 0);
    wait_quiet("quiet_after_reset", 2000);

    chk("leftover_bytes", byte_q.size(), 0);
    chk("leftover_frames", frame_q.size(), 0);
    chk("leftover_aborts", abort_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
